// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC/IF sequencer: default widths, reset vector and FSM state encoding.
package pc_fetch_sequencer_pkg;

   localparam int          DEF_XLEN         = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam int          DEF_CNT_W        = 16;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_ARB    = 2'd1,
      ST_IFETCH = 2'd2,
      ST_DMEM   = 2'd3
   } fsm_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable, holds at all-ones.
module pc_fetch_sequencer_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Sequences PC load and IF fetch, arbitrating the shared memory port between fetch and MEM-stage
// data access, with stall, redirect (latched while the port is busy) and IF/ID flush handling.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int              XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter int              CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  pc_i,
   output logic             pc_load,
   output logic [XLEN-1:0]  pc_next,
   input  logic             stall_i,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_target,
   input  logic             dmem_req,
   output logic             dmem_grant,
   output logic             fetch_req,
   output logic [XLEN-1:0]  fetch_addr,
   input  logic             mem_ready,
   output logic             if_valid,
   output logic             ifid_flush,
   output logic             misalign,
   output logic [CNT_W-1:0] stall_cycles
);

   fsm_state_e      state_q, state_d;
   logic            redir_pend_q, redir_pend_d;
   logic [XLEN-1:0] redir_tgt_q, redir_tgt_d;
   logic [XLEN-1:0] tgt_aligned;
   logic            stall_cnt_en;

   assign tgt_aligned = {redirect_target[XLEN-1:2], 2'b00};
   assign fetch_addr  = pc_i;

   always_comb begin
      state_d      = state_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
      pc_load      = 1'b0;
      pc_next      = pc_i;
      fetch_req    = 1'b0;
      dmem_grant   = 1'b0;
      if_valid     = 1'b0;
      ifid_flush   = 1'b0;
      misalign     = 1'b0;
      stall_cnt_en = 1'b0;

      if (!rst) begin
         state_d      = ST_BOOT;
         redir_pend_d = 1'b0;
         pc_load      = 1'b1;
         pc_next      = RESET_VECTOR;
      end else begin
         misalign = (state_q != ST_BOOT) && redirect_valid && (redirect_target[1:0] != 2'b00);
         case (state_q)
            ST_BOOT: begin
               pc_load = 1'b1;
               pc_next = RESET_VECTOR;
               state_d = ST_ARB;
            end
            ST_ARB: begin
               // A fresh redirect beats a stored one: youngest target wins.
               if (redirect_valid || redir_pend_q) begin
                  pc_load      = 1'b1;
                  pc_next      = redirect_valid ? tgt_aligned : redir_tgt_q;
                  ifid_flush   = 1'b1;
                  redir_pend_d = 1'b0;
               end else if (dmem_req) begin
                  state_d = ST_DMEM;
               end else if (!stall_i) begin
                  state_d = ST_IFETCH;
               end else begin
                  stall_cnt_en = 1'b1;
               end
            end
            ST_IFETCH: begin
               fetch_req = 1'b1;
               if (mem_ready) begin
                  state_d = ST_ARB;
                  if (redirect_valid) begin
                     ifid_flush   = 1'b1;
                     pc_load      = 1'b1;
                     pc_next      = tgt_aligned;
                     redir_pend_d = 1'b0;
                  end else if (redir_pend_q) begin
                     ifid_flush = 1'b1;
                  end else begin
                     if_valid = 1'b1;
                     pc_load  = 1'b1;
                     pc_next  = pc_i + XLEN'(4);
                  end
               end else if (redirect_valid) begin
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = tgt_aligned;
               end
            end
            ST_DMEM: begin
               dmem_grant = 1'b1;
               if (redirect_valid) begin
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = tgt_aligned;
               end
               if (mem_ready) begin
                  state_d = ST_ARB;
               end
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_BOOT;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= '0;
      end else begin
         state_q      <= state_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
      end
   end

   pc_fetch_sequencer_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clr   (!rst),
      .en    (stall_cnt_en),
      .count (stall_cycles)
   );

   // The data side must hold its request until the access completes.
   a_dmem_req_held : assert property (@(posedge clk) disable iff (!rst)
      ((state_q == ST_DMEM) && !mem_ready) |-> dmem_req);

endmodule
